mem_arbiter: RTL

Two-port memory arbiter that lets the multi-cycle MIPS core's instruction-fetch port and data port share a single-ported unified memory. It sits between the core (instruction and data request ports) and the memory, serialises accesses with round-robin fairness, and applies a bounded-wait watchdog so a stalled memory cannot hang the core.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side request ports and the memory-side access port of mem_arbiter.
// Ports: fetch channel (i_*), data channel (d_*), unified memory channel (mem_*).
// The slave modport is the arbiter's view; the master modport is the core/memory side.
interface mem_arbiter_if;
   // instruction fetch channel
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   // data channel
   logic        d_req;
   logic        d_rd_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   // memory channel
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd_wr;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_req, mem_addr, mem_wdata, mem_rd_wr
   );

   modport master (
      output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_req, mem_addr, mem_wdata, mem_rd_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and data ports.
// Latency: grant edge -> mem_req next cycle; mem_ready edge -> one-cycle ack after it.
// Backpressure: requesters hold req until ack; a memory stall is cut off by a TIMEOUT watchdog.
// Ports: clk, reset (async, active-high) and bus (mem_arbiter_if.slave) carrying
// i_* fetch channel, d_* data channel and mem_* memory channel.
module mem_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [31:0] RESET_ADDR = 32'h80020000
) (
   input  logic clk,
   input  logic reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;      // 1 when the data port was granted most recently
   logic [7:0]  wait_q, wait_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_rd_wr_q, mem_rd_wr_d;
   logic        i_ack_q, i_ack_d, i_err_q, i_err_d;
   logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic        i_elig, d_elig, grant_i, grant_d, expired;

   // A port still showing its ack this cycle has just been served and must not be re-granted.
   assign i_elig  = bus.i_req & ~i_ack_q;
   assign d_elig  = bus.d_req & ~d_ack_q;
   assign grant_i = i_elig & (~d_elig | last_d_q);
   assign grant_d = d_elig & ~grant_i;
   assign expired = (wait_q == WAIT_LIMIT);

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      wait_d      = wait_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_wr_d = mem_rd_wr_q;
      i_ack_d     = 1'b0;
      i_err_d     = 1'b0;
      d_ack_d     = 1'b0;
      d_err_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_i) begin
               mem_addr_d  = bus.i_addr;
               mem_wdata_d = 32'h0;
               mem_rd_wr_d = 1'b1;
               mem_req_d   = 1'b1;
               wait_d      = 8'h0;
               last_d_d    = 1'b0;
               state_d     = BUSY_I;
            end else if (grant_d) begin
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               mem_rd_wr_d = bus.d_rd_wr;
               mem_req_d   = 1'b1;
               wait_d      = 8'h0;
               last_d_d    = 1'b1;
               state_d     = BUSY_D;
            end
         end
         BUSY_I: begin
            if (bus.mem_ready) begin
               i_ack_d   = 1'b1;
               i_rdata_d = bus.mem_rdata;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (expired) begin
               i_ack_d   = 1'b1;
               i_err_d   = 1'b1;
               i_rdata_d = 32'h0;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (wait_q != 8'hFF) begin
               wait_d = wait_q + 8'd1;
            end
         end
         BUSY_D: begin
            if (bus.mem_ready) begin
               d_ack_d   = 1'b1;
               d_rdata_d = mem_rd_wr_q ? bus.mem_rdata : 32'h0;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (expired) begin
               d_ack_d   = 1'b1;
               d_err_d   = 1'b1;
               d_rdata_d = 32'h0;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (wait_q != 8'hFF) begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         wait_q      <= 8'h0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= RESET_ADDR;
         mem_wdata_q <= 32'h0;
         mem_rd_wr_q <= 1'b1;
         i_ack_q     <= 1'b0;
         i_err_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         i_rdata_q   <= 32'h0;
         d_rdata_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         wait_q      <= wait_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_wr_q <= mem_rd_wr_d;
         i_ack_q     <= i_ack_d;
         i_err_q     <= i_err_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_rd_wr = mem_rd_wr_q;
   assign bus.i_ack     = i_ack_q;
   assign bus.i_err     = i_err_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_err     = d_err_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule
